// File: rtl/quad_spike_encoder.sv
// quad_spike_encoder: two quadrature encoders -> filtered, rate-limited direction spikes.
// Define QUAD_ERR_CNT_EN to build the saturating illegal-transition counter on o_err_cnt.
module quad_spike_encoder #(
  parameter int FILT_LEN = 3,
  parameter int PEND_W   = 4,
  parameter int GAP      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_qx_a,
  input  logic       i_qx_b,
  input  logic       i_qy_a,
  input  logic       i_qy_b,
  input  logic       i_enable,
  input  logic       i_clr,
  output logic [3:0] o_spike_out,
  output logic       o_ovf,
  output logic [7:0] o_err_cnt
);

  localparam int FCW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam int GCW = (GAP < 2) ? 1 : $clog2(GAP);
  localparam int SW  = PEND_W + 2;
  localparam logic signed [SW-1:0] LIM_HI = SW'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [SW-1:0] LIM_LO = -LIM_HI;
  localparam logic signed [SW-1:0] ONE    = SW'(1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  logic [3:0]          w_raw;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          r_filt;
  logic [3:0]          r_prev;
  logic [3:0][FCW-1:0] r_fcnt;
  logic [1:0][1:0]     w_cur;
  logic [1:0][1:0]     w_prv;
  logic [1:0]          w_stepUp;
  logic [1:0]          w_stepDn;
  logic [1:0]          w_drop;
  logic [1:0]          w_spikeP;
  logic [1:0]          w_spikeN;
  logic                r_ovf;

  // Bit order: [0] X.a, [1] X.b, [2] Y.a, [3] Y.b
  assign w_raw = {i_qy_b, i_qy_a, i_qx_b, i_qx_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A new level is accepted only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
      r_fcnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_fcnt[i] == FCW'(FILT_LEN - 1)) begin
            r_filt[i] <= r_sync2[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + 1'b1;
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= r_filt;
    end
  end

  assign w_cur[0] = {r_filt[0], r_filt[1]};
  assign w_cur[1] = {r_filt[2], r_filt[3]};
  assign w_prv[0] = {r_prev[0], r_prev[1]};
  assign w_prv[1] = {r_prev[2], r_prev[3]};

  function automatic logic [1:0] fwdOf(input logic [1:0] s);
    case (s)
      2'b00:   fwdOf = 2'b01;
      2'b01:   fwdOf = 2'b11;
      2'b11:   fwdOf = 2'b10;
      default: fwdOf = 2'b00;
    endcase
  endfunction

  always_comb begin
    w_stepUp = '0;
    w_stepDn = '0;
    for (int ax = 0; ax < 2; ax++) begin
      if (w_cur[ax] != w_prv[ax]) begin
        if (w_cur[ax] == fwdOf(w_prv[ax])) begin
          w_stepUp[ax] = 1'b1;
        end else if (w_prv[ax] == fwdOf(w_cur[ax])) begin
          w_stepDn[ax] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gAxis
    state_t                   r_state;
    state_t                   w_next;
    logic [GCW-1:0]           r_gapCnt;
    logic signed [PEND_W-1:0] r_pend;
    logic signed [SW-1:0]     w_base;
    logic signed [SW-1:0]     w_sum;
    logic                     w_pos;
    logic                     w_neg;
    logic                     w_emitP;
    logic                     w_emitN;
    logic                     w_ovRange;
    logic                     w_pulseP;
    logic                     w_pulseN;
    logic                     r_spikeP;
    logic                     r_spikeN;

    assign w_pos   = ~r_pend[PEND_W-1] & (|r_pend);
    assign w_neg   = r_pend[PEND_W-1];
    assign w_emitP = i_enable & (r_state == S_IDLE) & w_pos;
    assign w_emitN = i_enable & (r_state == S_IDLE) & w_neg;

    // The emit term is applied first, so a step is dropped only when the counter truly saturates
    always_comb begin
      w_base = {{2{r_pend[PEND_W-1]}}, r_pend};
      if (w_emitP) begin
        w_base = w_base - ONE;
      end else if (w_emitN) begin
        w_base = w_base + ONE;
      end
      w_sum = w_base;
      if (w_stepUp[g]) begin
        w_sum = w_base + ONE;
      end else if (w_stepDn[g]) begin
        w_sum = w_base - ONE;
      end
      w_ovRange = (w_sum > LIM_HI) || (w_sum < LIM_LO);
    end

    assign w_drop[g] = i_enable & (w_stepUp[g] | w_stepDn[g]) & w_ovRange;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pend <= '0;
      end else if (!i_enable) begin
        r_pend <= '0;
      end else if (w_drop[g]) begin
        r_pend <= w_base[PEND_W-1:0];
      end else begin
        r_pend <= w_sum[PEND_W-1:0];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state  <= S_IDLE;
        r_gapCnt <= '0;
        r_spikeP <= 1'b0;
        r_spikeN <= 1'b0;
      end else begin
        r_state  <= w_next;
        r_gapCnt <= ((r_state == S_GAP) && (w_next == S_GAP)) ? r_gapCnt + 1'b1 : '0;
        r_spikeP <= w_pulseP;
        r_spikeN <= w_pulseN;
      end
    end

    always_comb begin
      w_next = r_state;
      if (!i_enable) begin
        w_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  if (w_emitP || w_emitN) w_next = S_PULSE;
          S_PULSE: w_next = S_GAP;
          S_GAP:   if (r_gapCnt == GCW'(GAP - 1)) w_next = S_IDLE;
          default: w_next = S_IDLE;
        endcase
      end
    end

    // PULSE is only entered from IDLE, so the sign of pend picks the spike bit
    always_comb begin
      w_pulseP = (r_state == S_IDLE) && (w_next == S_PULSE) && w_pos;
      w_pulseN = (r_state == S_IDLE) && (w_next == S_PULSE) && w_neg;
    end

    assign w_spikeP[g] = r_spikeP;
    assign w_spikeN[g] = r_spikeN;
  end

  assign o_spike_out = {w_spikeN[1], w_spikeN[0], w_spikeP[1], w_spikeP[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_ovf = r_ovf;

`ifdef QUAD_ERR_CNT_EN
  logic [1:0] w_ill;
  logic [1:0] w_illCnt;
  logic [8:0] w_errSum;
  logic [7:0] r_errCnt;

  always_comb begin
    w_ill = '0;
    for (int ax = 0; ax < 2; ax++) begin
      w_ill[ax] = i_enable && (w_cur[ax] != w_prv[ax]) && !w_stepUp[ax] && !w_stepDn[ax];
    end
  end

  // A clear coinciding with new illegal events keeps those events counted
  assign w_illCnt = {1'b0, w_ill[0]} + {1'b0, w_ill[1]};
  assign w_errSum = (i_clr ? 9'd0 : {1'b0, r_errCnt}) + {7'd0, w_illCnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errCnt <= '0;
    end else begin
      r_errCnt <= w_errSum[8] ? 8'hFF : w_errSum[7:0];
    end
  end

  assign o_err_cnt = r_errCnt;
`else
  assign o_err_cnt = '0;
`endif

endmodule
